// File: rtl/div_unit.sv
// ---- div_unit : radix-2 restoring divider for DIV/DIVU, {rem, quot} result (rev 1.0) ----
`default_nettype none

module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  start,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W-1:0]   rem;
  logic                neg_q;
  logic                neg_r;

  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  logic                fits;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                go;

  assign go = start && !annul;

  // Magnitudes of the operands; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  assign op1_abs = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign op2_abs = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the difference only when it did not go negative.
  assign rem_sh = {rem, dvd[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign fits   = ~diff[DATA_W];

  assign quot_fix = neg_q ? -dvd : dvd;
  assign rem_fix  = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (go) begin
          state_nxt = (opdata2 == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: state_nxt = END;
      ON: begin
        if (annul) begin
          state_nxt = FREE;
        end else if (cnt == LAST_CNT) begin
          state_nxt = END;
        end
      end
      END: begin
        if (!start) begin
          state_nxt = FREE;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result <= '0;
          ready  <= 1'b0;
          if (go && (opdata2 != '0)) begin
            dvd   <= op1_abs;
            dvs   <= op2_abs;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r <= signed_div && opdata1[DATA_W-1];
          end
        end
        BY_ZERO: begin
          result <= '0;
          ready  <= 1'b0;
        end
        ON: begin
          ready <= 1'b0;
          if (!annul) begin
            if (cnt != LAST_CNT) begin
              rem <= fits ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
              dvd <= {dvd[DATA_W-2:0], fits};
              cnt <= cnt + CNT_W'(1);
            end else begin
              result <= {rem_fix, quot_fix};
              ready  <= 1'b1;
            end
          end
        end
        END: begin
          // The zero-divisor path arrives here with ready low; it rises one
          // edge later, and the result stays held until start drops.
          if (!start) begin
            ready  <= 1'b0;
            result <= '0;
          end else begin
            ready  <= 1'b1;
          end
        end
        default: begin
          ready  <= 1'b0;
          result <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; serves DIV and DIVU.
- Radix-2 restoring shift-subtract, one quotient bit per clock; 64-bit {remainder, quotient} result feeds HI/LO writeback.
- The EX stage raises stall_from_ex to ctrl while start is high and ready is low; this freezes stages 0-3 until the result is ready.
- annul lets the pipeline abandon an in-flight divide on flush.

Parameters:
- DATA_W, 32, operand width; quotient and remainder widths; the result is 2*DATA_W.
- CNT_W, 6, width of the iteration counter; must hold the value DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start in FREE
- opdata1  input  DATA_W  dividend; sampled with start in FREE
- opdata2  input  DATA_W  divisor; sampled with start in FREE
- start  input  1  request; held high by EX until ready is seen
- annul  input  1  abort the current divide; effective in ON state
- result  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid while ready=1
- ready  output  1  result valid; high only in END state

Behaviour:
- Reset (asynchronous, any state): state=FREE, cnt=0, result=0, ready=0, internal dividend/divisor registers=0.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start=1, annul=0, opdata2=0 -> BY_ZERO.
  - start=1, annul=0, opdata2!=0 -> ON. Latch operands, taking absolute values when signed_div=1 and the operand MSB=1. Latch the signs. cnt=0. Partial remainder=0.
  - Otherwise stay in FREE; ready=0, result=0.
- BY_ZERO: next edge -> END with result=0 (quotient 0, remainder 0). No exception is raised.
- ON:
  - annul=1 -> FREE next edge; ready stays 0; no result produced.
  - cnt<DATA_W: shift {rem, dividend} left by 1. Trial-subtract the divisor. If non-negative, keep the difference and set the quotient LSB=1; else set the quotient LSB=0. cnt=cnt+1.
  - cnt==DATA_W: apply sign correction, load result, -> END.
- Sign correction (signed_div=1 only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign (truncating division).
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- END:
  - ready=1; result is held stable.
  - start=0 -> FREE next edge; ready=0, result=0.
  - start=1 stays in END; a new divide requires start to drop for at least one cycle.
  - annul is ignored in END.
- Latency, with the sampling edge as E0:
  - Normal divide: 32 iteration edges E1..E32; correction/load at E33; ready=1 after E33, i.e. 33 cycles of stall.
  - Divide-by-zero: ready=1 after E2.
- Simultaneous start and annul in FREE: annul wins and the state stays FREE.
- Operand inputs may change after E0 without effect.
- An asynchronous reset mid-divide discards all state immediately.

Test Plan:
- Unsigned divide: signed_div=0, 100/7, start held -> ready rises 33 cycles after the sampling edge; result = {0x00000002, 0x0000000E}; start dropped -> ready=0 next cycle.
- Signed negative: signed_div=1, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 0x12345678/0 -> ready after 2 edges, result=0. Also unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Overflow corner: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, ready after 33 cycles.
- Annul mid-operation: annul pulsed at edge E10 -> FREE, ready never asserts. A back-to-back start with 50/5 then completes with quotient 0x0000000A, remainder 0.
- Reset mid-operation: assert rst asynchronously at E15 -> ready=0 and result=0 immediately, without waiting for a clock edge. After release, unsigned 9/3 gives quotient 3, remainder 0.
